// File: rtl/pulldown_scanner.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module      : pulldown_scanner
//  Description : Time-multiplexed emulated pull-down controller. Banks of pins
//                are visited round-robin: driven low briefly, released, left
//                to settle, then sampled through a two-flop synchronizer and
//                debounced per bit. Debounced changes are posted one bank at a
//                time on a valid/ready event port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulldown_scanner #(
    parameter int BANKS            = 4,
    parameter int WIDTH            = 8,
    parameter int DISCHARGE_CYCLES = 1,
    parameter int SETTLE_CYCLES    = 12,
    parameter int DEBOUNCE         = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        enable,
    input  logic [BANKS*WIDTH-1:0]                      pins_in,
    output logic [BANKS-1:0]                            drive_low,
    output logic [BANKS*WIDTH-1:0]                      state,
    output logic                                        evt_valid,
    output logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] evt_bank,
    output logic [WIDTH-1:0]                            evt_mask,
    input  logic                                        evt_ready,
    output logic                                        scan_done
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int NB   = BANKS * WIDTH;
    localparam int CW   = $clog2(DEBOUNCE + 1);
    localparam int TMAX = (DISCHARGE_CYCLES > SETTLE_CYCLES) ? DISCHARGE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [BW-1:0] c_LAST_BANK  = BW'(BANKS - 1);
    localparam logic [CW-1:0] c_DB_MAX     = CW'(DEBOUNCE);
    localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);
    localparam logic [TW-1:0] c_DIS_LOAD   = TW'(DISCHARGE_CYCLES - 1);
    localparam logic [TW-1:0] c_SET_LOAD   = TW'(SETTLE_CYCLES - 1);

    // FSM encoding
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DISCHARGE = 3'd1;
    localparam logic [2:0] S_SETTLE    = 3'd2;
    localparam logic [2:0] S_SAMPLE    = 3'd3;
    localparam logic [2:0] S_COMMIT    = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NB-1:0]                 r_sync1;
    logic [NB-1:0]                 r_sync2;
    logic [2:0]                    r_fsm;
    logic [BW-1:0]                 r_bank;
    logic [TW-1:0]                 r_timer;
    logic [WIDTH-1:0]              r_sample;
    logic [BANKS-1:0]              r_drive_low;
    logic                          r_scan_done;
    logic [WIDTH-1:0]              r_state_b [BANKS];
    logic [WIDTH-1:0][CW-1:0]      r_db_cnt  [BANKS];
    logic                          r_evt_valid;
    logic [BW-1:0]                 r_evt_bank;
    logic [WIDTH-1:0]              r_evt_mask;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [2:0]                    w_fsm_nxt;
    logic [BW-1:0]                 w_bank_nxt;
    logic [TW-1:0]                 w_timer_nxt;
    logic [BANKS-1:0]              w_drive_nxt;
    logic [WIDTH-1:0]              w_cur_sync;
    logic [WIDTH-1:0]              w_cur_state;
    logic [WIDTH-1:0][CW-1:0]      w_cur_cnt;
    logic [WIDTH-1:0][CW-1:0]      w_cnt_upd;
    logic [WIDTH-1:0]              w_flip;
    logic                          w_slot_free;
    logic                          w_commit;
    logic                          w_in_commit;

    // Two-flop synchronizer on every pin; runs regardless of the scan state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pins_in;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state, bank index and phase timer for the scan sequencer
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_bank_nxt  = r_bank;
        w_timer_nxt = r_timer;
        case (r_fsm)
            S_IDLE: begin
                if (enable) begin
                    w_fsm_nxt   = S_DISCHARGE;
                    w_timer_nxt = c_DIS_LOAD;
                end
            end
            S_DISCHARGE: begin
                if (r_timer == '0) begin
                    w_fsm_nxt   = S_SETTLE;
                    w_timer_nxt = c_SET_LOAD;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_timer == '0) begin
                    w_fsm_nxt = S_SAMPLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_SAMPLE: begin
                w_fsm_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                // The bank index advances even when stopping, so a later
                // restart continues with the following bank.
                w_bank_nxt = (r_bank == c_LAST_BANK) ? '0 : r_bank + 1'b1;
                if (enable) begin
                    w_fsm_nxt   = S_DISCHARGE;
                    w_timer_nxt = c_DIS_LOAD;
                end else begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    // One-hot drive pattern for the next cycle: only the bank entering or
    // staying in DISCHARGE is pulled low, everything else floats.
    always_comb begin
        w_drive_nxt = '0;
        for (int b = 0; b < BANKS; b++) begin
            if ((w_fsm_nxt == S_DISCHARGE) && (w_bank_nxt == BW'(b))) begin
                w_drive_nxt[b] = 1'b1;
            end
        end
    end

    // Sequencer registers, registered drive and end-of-scan pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm       <= S_IDLE;
            r_bank      <= '0;
            r_timer     <= '0;
            r_drive_low <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_bank      <= w_bank_nxt;
            r_timer     <= w_timer_nxt;
            r_drive_low <= w_drive_nxt;
            r_scan_done <= (r_fsm == S_COMMIT) && (r_bank == c_LAST_BANK);
        end
    end

    // Select the current bank's synchronized pins, debounced state and counters
    always_comb begin
        w_cur_sync  = '0;
        w_cur_state = '0;
        w_cur_cnt   = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (r_bank == BW'(b)) begin
                w_cur_sync  = r_sync2[b*WIDTH +: WIDTH];
                w_cur_state = r_state_b[b];
                w_cur_cnt   = r_db_cnt[b];
            end
        end
    end

    // Capture the settled bank value at the sample point
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sample <= '0;
        end else if (r_fsm == S_SAMPLE) begin
            r_sample <= w_cur_sync;
        end
    end

    // Per-bit debounce step: a disagreeing sample advances the counter
    // (saturating), an agreeing one clears it. Reaching the limit marks the
    // bit as ready to flip.
    always_comb begin
        w_cnt_upd = '0;
        w_flip    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_sample[i] == w_cur_state[i]) begin
                w_cnt_upd[i] = '0;
            end else if (w_cur_cnt[i] == c_DB_MAX) begin
                w_cnt_upd[i] = w_cur_cnt[i];
            end else begin
                w_cnt_upd[i] = w_cur_cnt[i] + c_CNT_ONE;
            end
            w_flip[i] = (w_cnt_upd[i] == c_DB_MAX);
        end
    end

    // A commit only happens when the event can be posted, so a state change
    // and its report always travel together.
    assign w_in_commit = (r_fsm == S_COMMIT);
    assign w_slot_free = !r_evt_valid || evt_ready;
    assign w_commit    = w_in_commit && (w_flip != '0) && w_slot_free;

    // Debounced state and counters for the bank being committed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < BANKS; b++) begin
                r_state_b[b] <= '0;
                r_db_cnt[b]  <= '0;
            end
        end else if (w_in_commit) begin
            for (int b = 0; b < BANKS; b++) begin
                if (r_bank == BW'(b)) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        // Without a free slot the counter stays saturated so
                        // the flip is retried on the next visit.
                        r_db_cnt[b][i] <= (w_commit && w_flip[i]) ? '0 : w_cnt_upd[i];
                    end
                    if (w_commit) begin
                        r_state_b[b] <= r_state_b[b] ^ w_flip;
                    end
                end
            end
        end
    end

    // Single-entry event slot: load on commit, clear on handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_bank  <= '0;
            r_evt_mask  <= '0;
        end else if (w_commit) begin
            r_evt_valid <= 1'b1;
            r_evt_bank  <= r_bank;
            r_evt_mask  <= w_flip;
        end else if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    // Pack per-bank debounced state onto the flat output bus
    generate
        for (genvar gb = 0; gb < BANKS; gb++) begin : g_state_pack
            assign state[gb*WIDTH +: WIDTH] = r_state_b[gb];
        end
    endgenerate

    assign drive_low = r_drive_low;
    assign scan_done = r_scan_done;
    assign evt_valid = r_evt_valid;
    assign evt_bank  = r_evt_bank;
    assign evt_mask  = r_evt_mask;

endmodule
`default_nettype wire
